// File: rtl/noc_pkg.sv
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC definitions: default adapter geometry and the
//               flit record carried between PE, adapter and router.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_pkg;

    localparam int c_DATA_WIDTH = 8;
    localparam int c_VICH       = 2;
    localparam int c_VICH_ADDR  = (c_VICH > 1) ? $clog2(c_VICH) : 1;
    localparam int c_FIFO_DEPTH = 4;
    localparam int c_STAT_WIDTH = 16;

    // A flit as seen on any adapter channel: virtual channel plus payload.
    typedef struct packed {
        logic [c_VICH_ADDR-1:0]  sel;
        logic [c_DATA_WIDTH-1:0] data;
    } flit_t;

endpackage

`default_nettype wire

// File: rtl/pe_adapter_fifo.sv
// ============================================================================
// Module      : pe_adapter_fifo
// Description : Synchronous single-clock FIFO with registered full/empty
//               flags and a combinational head output. Depth must be a
//               power of two; pointers carry one extra wrap bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_adapter_fifo
    import noc_pkg::*;
#(
    parameter int Width = c_DATA_WIDTH,
    parameter int Depth = c_FIFO_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [Width-1:0] i_pushData,
    input  logic             i_pop,
    output logic [Width-1:0] o_popData,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_ADDR_W = $clog2(Depth);

    logic [Width-1:0]  r_mem [Depth];
    logic [c_ADDR_W:0] r_wrPtr;
    logic [c_ADDR_W:0] r_rdPtr;
    logic              w_doPush;
    logic              w_doPop;

    // Flags come straight from the registered pointers, so a full FIFO
    // refuses a push even when it is popped in the same cycle.
    assign o_empty   = (r_wrPtr == r_rdPtr);
    assign o_full    = (r_wrPtr[c_ADDR_W] != r_rdPtr[c_ADDR_W]) &&
                       (r_wrPtr[c_ADDR_W-1:0] == r_rdPtr[c_ADDR_W-1:0]);
    assign w_doPush  = i_push && !o_full;
    assign w_doPop   = i_pop && !o_empty;
    assign o_popData = r_mem[r_rdPtr[c_ADDR_W-1:0]];

    // Pointer update; reset empties the FIFO regardless of its contents.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + (c_ADDR_W+1)'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + (c_ADDR_W+1)'(1);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (w_doPush) r_mem[r_wrPtr[c_ADDR_W-1:0]] <= i_pushData;
    end

endmodule

`default_nettype wire

// File: rtl/pe_noc_adapter.sv
// ============================================================================
// Module      : pe_noc_adapter
// Description : PE <-> mesh NoC local-port adapter. Per-VC injection FIFOs
//               arbitrated round-robin into a registered injection stage,
//               and a two-entry skid buffer on the ejection path.
//               Optional feature macro: PE_ADAPTER_STATS_EN adds the
//               tx_count / rx_count handshake counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_noc_adapter
    import noc_pkg::*;
#(
    parameter int DataWidth = c_DATA_WIDTH,
    parameter int ViCh      = c_VICH,
    parameter int ViChAddr  = c_VICH_ADDR,
    parameter int FifoDepth = c_FIFO_DEPTH
`ifdef PE_ADAPTER_STATS_EN
    ,
    parameter int StatWidth = c_STAT_WIDTH
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DataWidth-1:0] pe_tx_data,
    input  logic                 pe_tx_en,
    input  logic [ViChAddr-1:0]  pe_tx_sel,
    output logic [ViCh-1:0]      pe_tx_ready,
    output logic [DataWidth-1:0] noc_inj_data,
    output logic                 noc_inj_en,
    output logic [ViChAddr-1:0]  noc_inj_sel,
    input  logic                 noc_inj_ready,
    input  logic [DataWidth-1:0] noc_ej_data,
    input  logic                 noc_ej_en,
    input  logic [ViChAddr-1:0]  noc_ej_sel,
    output logic                 noc_ej_ready,
    output logic [DataWidth-1:0] pe_rx_data,
    output logic                 pe_rx_en,
    output logic [ViChAddr-1:0]  pe_rx_sel,
    input  logic                 pe_rx_ready
`ifdef PE_ADAPTER_STATS_EN
    ,
    output logic [StatWidth-1:0] tx_count,
    output logic [StatWidth-1:0] rx_count
`endif
);

    // ---------------- injection path ----------------
    logic [ViCh-1:0]      w_full;
    logic [ViCh-1:0]      w_empty;
    logic [ViCh-1:0]      w_push;
    logic [ViCh-1:0]      w_pop;
    logic [DataWidth-1:0] w_fifoData [ViCh];

    logic                 r_injValid;
    logic [DataWidth-1:0] r_injData;
    logic [ViChAddr-1:0]  r_injSel;
    logic [ViChAddr-1:0]  r_lastGrant;

    logic                 w_load;
    logic                 w_grantFound;
    logic [ViChAddr-1:0]  w_grantVc;
    int                   w_idx;

    // A select value outside the VC range matches no FIFO, so the flit is dropped.
    generate
        for (genvar v = 0; v < ViCh; v++) begin : g_vc
            assign w_push[v] = pe_tx_en && (pe_tx_sel == ViChAddr'(v)) && !w_full[v];
            assign w_pop[v]  = w_load && w_grantFound && (w_grantVc == ViChAddr'(v));

            pe_adapter_fifo #(
                .Width (DataWidth),
                .Depth (FifoDepth)
            ) u_fifo (
                .clock      (clock),
                .reset      (reset),
                .i_push     (w_push[v]),
                .i_pushData (pe_tx_data),
                .i_pop      (w_pop[v]),
                .o_popData  (w_fifoData[v]),
                .o_full     (w_full[v]),
                .o_empty    (w_empty[v])
            );
        end
    endgenerate

    assign pe_tx_ready  = reset ? ~w_full : '0;
    assign w_load       = !r_injValid || noc_inj_ready;
    assign noc_inj_en   = r_injValid;
    assign noc_inj_data = r_injData;
    assign noc_inj_sel  = r_injSel;

    // Round-robin pick: first non-empty FIFO searching from last grant + 1.
    always_comb begin
        w_grantFound = 1'b0;
        w_grantVc    = '0;
        w_idx        = 0;
        for (int i = 1; i <= ViCh; i++) begin
            w_idx = (int'(r_lastGrant) + i) % ViCh;
            if (!w_grantFound && !w_empty[ViChAddr'(w_idx)]) begin
                w_grantFound = 1'b1;
                w_grantVc    = ViChAddr'(w_idx);
            end
        end
    end

    // Injection output register; the grant pointer only moves when a flit loads.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_injValid  <= 1'b0;
            r_injData   <= '0;
            r_injSel    <= '0;
            r_lastGrant <= ViChAddr'(ViCh - 1);
        end else if (w_load) begin
            r_injValid <= w_grantFound;
            if (w_grantFound) begin
                r_injData   <= w_fifoData[w_grantVc];
                r_injSel    <= w_grantVc;
                r_lastGrant <= w_grantVc;
            end
        end
    end

    // ---------------- ejection path ----------------
    logic [DataWidth-1:0] r_ejData [2];
    logic [ViChAddr-1:0]  r_ejSel  [2];
    logic                 r_ejHead;
    logic [1:0]           r_ejCount;
    logic                 w_ejAccept;
    logic                 w_rxPop;
    logic                 w_ejTail;

    assign noc_ej_ready = reset && (r_ejCount != 2'd2);
    assign pe_rx_en     = (r_ejCount != 2'd0);
    assign pe_rx_data   = r_ejData[r_ejHead];
    assign pe_rx_sel    = r_ejSel[r_ejHead];
    assign w_ejAccept   = noc_ej_en && noc_ej_ready;
    assign w_rxPop      = pe_rx_en && pe_rx_ready;
    assign w_ejTail     = r_ejHead ^ r_ejCount[0];

    // Two-entry circular skid buffer; an accepted flit is visible to the PE next cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                r_ejData[i] <= '0;
                r_ejSel[i]  <= '0;
            end
            r_ejHead  <= 1'b0;
            r_ejCount <= 2'd0;
        end else begin
            if (w_ejAccept) begin
                r_ejData[w_ejTail] <= noc_ej_data;
                r_ejSel[w_ejTail]  <= noc_ej_sel;
            end
            if (w_rxPop) r_ejHead <= ~r_ejHead;
            r_ejCount <= r_ejCount + {1'b0, w_ejAccept} - {1'b0, w_rxPop};
        end
    end

`ifdef PE_ADAPTER_STATS_EN
    logic [StatWidth-1:0] r_txCount;
    logic [StatWidth-1:0] r_rxCount;

    assign tx_count = r_txCount;
    assign rx_count = r_rxCount;

    // Handshake counters, wrapping naturally at 2^StatWidth.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_txCount <= '0;
            r_rxCount <= '0;
        end else begin
            if (r_injValid && noc_inj_ready) r_txCount <= r_txCount + StatWidth'(1);
            if (w_rxPop)                     r_rxCount <= r_rxCount + StatWidth'(1);
        end
    end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe_noc_adapter.sv
// ============================================================================
// Module      : tb_pe_noc_adapter
// Description : Self-checking bench for pe_noc_adapter. A queue-based
//               reference model predicts every output each cycle under
//               directed and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_noc_adapter;
    import noc_pkg::*;

    localparam int DW    = 8;
    localparam int VC    = 2;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] pe_tx_data;
    logic          pe_tx_en;
    logic [0:0]    pe_tx_sel;
    logic [VC-1:0] pe_tx_ready;
    logic [DW-1:0] noc_inj_data;
    logic          noc_inj_en;
    logic [0:0]    noc_inj_sel;
    logic          noc_inj_ready;
    logic [DW-1:0] noc_ej_data;
    logic          noc_ej_en;
    logic [0:0]    noc_ej_sel;
    logic          noc_ej_ready;
    logic [DW-1:0] pe_rx_data;
    logic          pe_rx_en;
    logic [0:0]    pe_rx_sel;
    logic          pe_rx_ready;
`ifdef PE_ADAPTER_STATS_EN
    logic [15:0]   tx_count;
    logic [15:0]   rx_count;
`endif

    pe_noc_adapter dut (
        .clock         (clock),
        .reset         (reset),
        .pe_tx_data    (pe_tx_data),
        .pe_tx_en      (pe_tx_en),
        .pe_tx_sel     (pe_tx_sel),
        .pe_tx_ready   (pe_tx_ready),
        .noc_inj_data  (noc_inj_data),
        .noc_inj_en    (noc_inj_en),
        .noc_inj_sel   (noc_inj_sel),
        .noc_inj_ready (noc_inj_ready),
        .noc_ej_data   (noc_ej_data),
        .noc_ej_en     (noc_ej_en),
        .noc_ej_sel    (noc_ej_sel),
        .noc_ej_ready  (noc_ej_ready),
        .pe_rx_data    (pe_rx_data),
        .pe_rx_en      (pe_rx_en),
        .pe_rx_sel     (pe_rx_sel),
        .pe_rx_ready   (pe_rx_ready)
`ifdef PE_ADAPTER_STATS_EN
        ,
        .tx_count      (tx_count),
        .rx_count      (rx_count)
`endif
    );

    always #5 clock = ~clock;

    // ---------------- reference model state ----------------
    logic [DW-1:0] mq [VC][$];
    bit            mOutValid;
    logic [DW-1:0] mOutData;
    int            mOutSel;
    int            mLast;
    flit_t         mEj[$];
    int            mTx;
    int            mRx;

    int            nCompared;
    int            nMismatched;

    int            injSelLog[$];
    logic [DW-1:0] injDataLog[$];
    logic [DW-1:0] rxDataLog[$];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic modelEdge();
        int    g;
        bit    load;
        bit    rxPop;
        bit    ejAcc;
        bit    pushOk;
        flit_t f;
        if (!reset) begin
            for (int v = 0; v < VC; v++) mq[v].delete();
            mEj.delete();
            mOutValid = 0;
            mOutData  = '0;
            mOutSel   = 0;
            mLast     = VC - 1;
            mTx       = 0;
            mRx       = 0;
            return;
        end
        if (mOutValid && noc_inj_ready) mTx++;
        pushOk = pe_tx_en && (int'(pe_tx_sel) < VC) && (mq[pe_tx_sel].size() < DEPTH);
        load   = !mOutValid || noc_inj_ready;
        if (load) begin
            g = -1;
            for (int i = 1; i <= VC; i++) begin
                if (g < 0 && mq[(mLast + i) % VC].size() > 0) g = (mLast + i) % VC;
            end
            if (g >= 0) begin
                mOutValid = 1;
                mOutData  = mq[g].pop_front();
                mOutSel   = g;
                mLast     = g;
            end else begin
                mOutValid = 0;
            end
        end
        if (pushOk) mq[pe_tx_sel].push_back(pe_tx_data);

        rxPop = (mEj.size() > 0) && pe_rx_ready;
        ejAcc = noc_ej_en && (mEj.size() < 2);
        if (rxPop) begin
            void'(mEj.pop_front());
            mRx++;
        end
        if (ejAcc) begin
            f.sel  = noc_ej_sel;
            f.data = noc_ej_data;
            mEj.push_back(f);
        end
    endtask

    task automatic checkOutputs();
        logic [VC-1:0] er;
        for (int v = 0; v < VC; v++) er[v] = reset && (mq[v].size() < DEPTH);
        checkVal("pe_tx_ready", 32'(pe_tx_ready), 32'(er));
        checkVal("noc_inj_en", 32'(noc_inj_en), 32'(mOutValid));
        if (mOutValid) begin
            checkVal("noc_inj_data", 32'(noc_inj_data), 32'(mOutData));
            checkVal("noc_inj_sel", 32'(noc_inj_sel), 32'(mOutSel));
        end
        checkVal("noc_ej_ready", 32'(noc_ej_ready), 32'(reset && (mEj.size() < 2)));
        checkVal("pe_rx_en", 32'(pe_rx_en), 32'(mEj.size() > 0));
        if (mEj.size() > 0) begin
            checkVal("pe_rx_data", 32'(pe_rx_data), 32'(mEj[0].data));
            checkVal("pe_rx_sel", 32'(pe_rx_sel), 32'(mEj[0].sel));
        end
`ifdef PE_ADAPTER_STATS_EN
        checkVal("tx_count", 32'(tx_count), mTx & 32'hFFFF);
        checkVal("rx_count", 32'(rx_count), mRx & 32'hFFFF);
`endif
    endtask

    // One clock: log upcoming handshakes, advance, then check mid-cycle.
    task automatic tick();
        if (noc_inj_en === 1'b1 && noc_inj_ready) begin
            injSelLog.push_back(int'(noc_inj_sel));
            injDataLog.push_back(noc_inj_data);
        end
        if (pe_rx_en === 1'b1 && pe_rx_ready) rxDataLog.push_back(pe_rx_data);
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        checkOutputs();
    endtask

    task automatic idle();
        pe_tx_en      = 0;
        pe_tx_data    = '0;
        pe_tx_sel     = '0;
        noc_inj_ready = 1;
        noc_ej_en     = 0;
        noc_ej_data   = '0;
        noc_ej_sel    = '0;
        pe_rx_ready   = 1;
    endtask

    task automatic randomInputs();
        pe_tx_en      = ($urandom_range(0, 9) < 7);
        pe_tx_data    = DW'($urandom);
        pe_tx_sel     = 1'($urandom_range(0, 1));
        noc_inj_ready = ($urandom_range(0, 9) < 6);
        noc_ej_en     = ($urandom_range(0, 9) < 5);
        noc_ej_data   = DW'($urandom);
        noc_ej_sel    = 1'($urandom_range(0, 1));
        pe_rx_ready   = ($urandom_range(0, 9) < 6);
    endtask

    task automatic resetPulse();
        idle();
        reset = 0;
        tick();
        reset = 1;
    endtask

    initial begin
        bit accepted;
        nCompared   = 0;
        nMismatched = 0;
        mLast       = VC - 1;
        idle();
        reset = 0;
        repeat (3) tick();
        reset = 1;
        tick();

        // Single flit: push at edge 0, visible after edge 1 for one cycle.
        pe_tx_data = 8'hA5; pe_tx_sel = 1; pe_tx_en = 1; noc_inj_ready = 1;
        tick();
        pe_tx_en = 0;
        checkVal("single_latency", 32'(noc_inj_en), 32'd0);
        tick();
        checkVal("single_en", 32'(noc_inj_en), 32'd1);
        checkVal("single_data", 32'(noc_inj_data), 32'hA5);
        checkVal("single_sel", 32'(noc_inj_sel), 32'd1);
        tick();
        checkVal("single_once", 32'(noc_inj_en), 32'd0);

        // Fill / backpressure on VC0.
        resetPulse();
        noc_inj_ready = 0;
        for (int i = 0; i < 5; i++) begin
            pe_tx_sel = 0; pe_tx_data = DW'(8'h10 + i); pe_tx_en = 1;
            tick();
        end
        checkVal("fill_ready0", 32'(pe_tx_ready[0]), 32'd0);
        pe_tx_data = 8'h99;
        tick();
        pe_tx_en = 0;
        injDataLog.delete();
        noc_inj_ready = 1;
        repeat (8) tick();
        checkVal("fill_count", 32'(injDataLog.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < injDataLog.size()) checkVal("fill_order", 32'(injDataLog[i]), 32'h10 + i);

        // Round robin: alternating preload, then drain.
        resetPulse();
        noc_inj_ready = 0;
        for (int i = 0; i < 6; i++) begin
            pe_tx_sel = 1'(i % 2); pe_tx_data = DW'(8'h20 + i); pe_tx_en = 1;
            tick();
        end
        pe_tx_en = 0;
        injSelLog.delete();
        noc_inj_ready = 1;
        repeat (8) tick();
        checkVal("rr_count", 32'(injSelLog.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < injSelLog.size()) checkVal("rr_order", 32'(injSelLog[i]), 32'(i % 2));

        // Ejection stall with PE not ready.
        resetPulse();
        pe_rx_ready = 0;
        for (int i = 0; i < 2; i++) begin
            noc_ej_en = 1; noc_ej_data = DW'(8'h30 + i); noc_ej_sel = 1'(i % 2);
            tick();
        end
        checkVal("ej_stall_ready", 32'(noc_ej_ready), 32'd0);
        noc_ej_data = 8'h32; noc_ej_sel = 0;
        tick();
        checkVal("ej_stall_hold", 32'(noc_ej_ready), 32'd0);
        rxDataLog.delete();
        pe_rx_ready = 1;
        accepted = 0;
        for (int w = 0; w < 10 && !accepted; w++) begin
            accepted = noc_ej_ready;
            tick();
        end
        checkVal("ej_third_accepted", 32'(accepted), 32'd1);
        noc_ej_en = 0;
        repeat (4) tick();
        checkVal("ej_count", 32'(rxDataLog.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < rxDataLog.size()) checkVal("ej_order", 32'(rxDataLog[i]), 32'h30 + i);

        // Random traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            randomInputs();
            reset = ($urandom_range(0, 199) != 0);
            tick();
        end
        reset = 1;

        // Reset in the middle of traffic.
        for (int c = 0; c < 20; c++) begin randomInputs(); tick(); end
        reset = 0;
        for (int c = 0; c < 3; c++) begin randomInputs(); tick(); end
        checkVal("rst_tx_ready", 32'(pe_tx_ready), 32'd0);
        checkVal("rst_ej_ready", 32'(noc_ej_ready), 32'd0);
        checkVal("rst_inj_en", 32'(noc_inj_en), 32'd0);
        checkVal("rst_inj_data", 32'(noc_inj_data), 32'd0);
        checkVal("rst_inj_sel", 32'(noc_inj_sel), 32'd0);
        checkVal("rst_rx_en", 32'(pe_rx_en), 32'd0);
        checkVal("rst_rx_data", 32'(pe_rx_data), 32'd0);
        idle();
        reset = 1;
        tick();
        checkVal("post_rst_tx_ready", 32'(pe_tx_ready), 32'h3);
        checkVal("post_rst_ej_ready", 32'(noc_ej_ready), 32'd1);
        injDataLog.delete();
        rxDataLog.delete();
        repeat (5) tick();
        checkVal("post_rst_no_inj", 32'(injDataLog.size()), 32'd0);
        checkVal("post_rst_no_rx", 32'(rxDataLog.size()), 32'd0);

`ifdef PE_ADAPTER_STATS_EN
        // Counter wrap: 70000 handshakes on each path.
        resetPulse();
        for (int c = 0; c < 70000; c++) begin
            pe_tx_en = 1; pe_tx_sel = 1'($urandom_range(0, 1)); pe_tx_data = DW'($urandom);
            noc_ej_en = 1; noc_ej_data = DW'($urandom); noc_ej_sel = 1'($urandom_range(0, 1));
            tick();
        end
        pe_tx_en = 0;
        noc_ej_en = 0;
        repeat (4) tick();
        checkVal("tx_wrap", 32'(tx_count), 32'd4464);
        checkVal("rx_wrap", 32'(rx_count), 32'd4464);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

`default_nettype wire
